// File: rtl/vga_write_arbiter_if.sv
// Bundle between the reversi drawing engines (master) and the framebuffer write arbiter (slave).
// Wires only; no latency. The engines hold req for the whole burst and plot only while granted.
interface vga_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3
);
    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     plot_in;
    logic [N_REQ*X_W-1:0] x_in;
    logic [N_REQ*Y_W-1:0] y_in;
    logic [N_REQ*C_W-1:0] colour_in;
    logic [N_REQ-1:0]     grant;
    logic                 busy;
    logic [X_W-1:0]       out_x;
    logic [Y_W-1:0]       out_y;
    logic [C_W-1:0]       out_colour;
    logic                 out_plot;
    logic [15:0]          burst_count;
    logic                 err_timeout;

    modport master (
        output req, plot_in, x_in, y_in, colour_in,
        input  grant, busy, out_x, out_y, out_colour, out_plot, burst_count, err_timeout
    );

    modport slave (
        input  req, plot_in, x_in, y_in, colour_in,
        output grant, busy, out_x, out_y, out_colour, out_plot, burst_count, err_timeout
    );
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA framebuffer write port among the drawing engines.
// Latency: grant one edge after req in IDLE; pixel one edge after its plot strobe; 2-cycle gap between grants.
// Backpressure: losers simply wait with req held; a silent grant holder is revoked by the watchdog.
module vga_write_arbiter #(
    parameter int N_REQ   = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                resetn,
    vga_write_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   gi_q, gi_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [C_W-1:0]     c_q, c_d;
    logic               plot_q, plot_d;
    logic [15:0]        burst_q, burst_d;
    logic [CNT_W-1:0]   idle_q, idle_d;
    logic               err_q, err_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rr_q    <= IDX_W'(N_REQ - 1);
            gi_q    <= '0;
            grant_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            plot_q  <= 1'b0;
            burst_q <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gi_q    <= gi_d;
            grant_q <= grant_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            plot_q  <= plot_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gi_d      = gi_q;
        grant_d   = grant_q;
        x_d       = x_q;
        y_d       = y_q;
        c_d       = c_q;
        plot_d    = 1'b0;
        burst_d   = burst_q;
        idle_d    = idle_q;
        err_d     = 1'b0;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;

        // Search starts just past the last winner so the previous holder goes last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % N_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    rr_d             = win_idx;
                    gi_d             = win_idx;
                    burst_d          = '0;
                    idle_d           = '0;
                    state_d          = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!bus.req[gi_q]) begin
                    // A strobe coinciding with the req drop is discarded.
                    grant_d = '0;
                    state_d = S_RELEASE;
                end else if (bus.plot_in[gi_q]) begin
                    x_d     = bus.x_in[X_W*gi_q +: X_W];
                    y_d     = bus.y_in[Y_W*gi_q +: Y_W];
                    c_d     = bus.colour_in[C_W*gi_q +: C_W];
                    plot_d  = 1'b1;
                    idle_d  = '0;
                    if (burst_q != 16'hFFFF) burst_d = burst_q + 16'd1;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                    if (TIMEOUT != 0 && (int'(idle_q) + 1) == TIMEOUT) begin
                        grant_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.out_x       = x_q;
    assign bus.out_y       = y_q;
    assign bus.out_colour  = c_q;
    assign bus.out_plot    = plot_q;
    assign bus.burst_count = burst_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: pixels are scoreboarded, grant/timing/watchdog behaviour checked directly.
module tb_vga_write_arbiter;
    localparam int N_REQ = 4;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int C_W   = 3;
    localparam int T     = 8;

    logic clk;
    logic resetn;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [X_W+Y_W+C_W-1:0] px_q[$];

    vga_write_arbiter_if #(.N_REQ(N_REQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus ();

    vga_write_arbiter #(
        .N_REQ(N_REQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TIMEOUT(T)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one requester's pixel slice and strobe; expect it at the output if push is set.
    task automatic drive_px(input int i, input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                            input logic [C_W-1:0] c, input bit push);
        bus.x_in[X_W*i +: X_W]      = x;
        bus.y_in[Y_W*i +: Y_W]      = y;
        bus.colour_in[C_W*i +: C_W] = c;
        bus.plot_in[i]              = 1'b1;
        if (push) px_q.push_back({x, y, c});
    endtask

    always @(negedge clk) begin
        if (resetn && bus.out_plot) begin
            if (px_q.size() == 0) check("unexpected_plot", 32'(bus.out_plot), 32'd0);
            else check("pixel", 32'({bus.out_x, bus.out_y, bus.out_colour}), 32'(px_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.req       = '0;
        bus.plot_in   = '0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.colour_in = '0;
        resetn        = 1'b1;
        #2 resetn     = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_plot", 32'(bus.out_plot), 32'd0);
        check("rst_xyc", 32'({bus.out_x, bus.out_y, bus.out_colour}), 32'd0);
        check("rst_burst", 32'(bus.burst_count), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single burst on requester 1.
        tick();
        bus.req[1] = 1'b1;
        tick();
        check("burst_grant", 32'(bus.grant), 32'b0010);
        check("burst_busy", 32'(bus.busy), 32'd1);
        drive_px(1, 8'd10, 7'd20, 3'b100, 1'b1);
        tick();
        check("burst_plot0", 32'(bus.out_plot), 32'd1);
        drive_px(1, 8'd11, 7'd20, 3'b100, 1'b1);
        tick();
        drive_px(1, 8'd12, 7'd20, 3'b100, 1'b1);
        tick();
        check("burst_plot2", 32'(bus.out_plot), 32'd1);
        bus.plot_in = '0;
        tick();
        check("burst_plot_off", 32'(bus.out_plot), 32'd0);
        check("burst_x_hold", 32'(bus.out_x), 32'd12);
        check("burst_count", 32'(bus.burst_count), 32'd3);
        bus.req[1] = 1'b0;
        tick();
        check("burst_rel_grant", 32'(bus.grant), 32'd0);
        check("burst_rel_busy", 32'(bus.busy), 32'd1);
        tick();
        check("burst_idle_busy", 32'(bus.busy), 32'd0);
        check("burst_count_hold", 32'(bus.burst_count), 32'd3);

        // Reset while requester 2 is mid-burst.
        bus.req[2] = 1'b1;
        tick();
        check("rstmid_grant", 32'(bus.grant), 32'b0100);
        drive_px(2, 8'd5, 7'd6, 3'd7, 1'b1);
        tick();
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("rstmid_grant0", 32'(bus.grant), 32'd0);
        check("rstmid_plot0", 32'(bus.out_plot), 32'd0);
        check("rstmid_x0", 32'(bus.out_x), 32'd0);
        check("rstmid_busy0", 32'(bus.busy), 32'd0);
        bus.req     = '0;
        bus.plot_in = '0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        bus.req = 4'b1111;
        tick();

        // Round robin with every requester briefly dropping req after one plot.
        for (int i = 0; i < 5; i++) begin
            int g;
            g = i % N_REQ;
            check("rr_grant", 32'(bus.grant), 32'(4'b0001 << g));
            if (i < 4) begin
                drive_px(g, 8'(i * 3), 7'(i + 1), 3'(i), 1'b1);
                tick();
                bus.plot_in = '0;
                bus.req[g]  = 1'b0;
                tick();
                check("rr_gap1", 32'(bus.grant), 32'd0);
                bus.req[g] = 1'b1;
                tick();
                check("rr_gap2", 32'({bus.grant, bus.out_plot}), 32'd0);
                tick();
            end
        end

        // Isolation: requester 3 strobes while 0 holds the grant.
        bus.req = 4'b0001;
        drive_px(3, 8'd99, 7'd1, 3'd1, 1'b0);
        tick();
        check("iso_plot", 32'(bus.out_plot), 32'd0);
        check("iso_x", 32'(bus.out_x), 32'd9);
        tick();
        check("iso_grant", 32'(bus.grant), 32'b0001);
        bus.plot_in = '0;
        bus.req     = '0;
        tick();
        tick();
        tick();

        // Watchdog: requester 2 never plots while 1 waits.
        bus.req = 4'b0100;
        tick();
        check("wd_grant", 32'(bus.grant), 32'b0100);
        check("wd_burst_clr", 32'(bus.burst_count), 32'd0);
        bus.req[1] = 1'b1;
        for (int e = 1; e < T; e++) tick();
        check("wd_before", 32'({bus.grant, bus.err_timeout}), 32'({4'b0100, 1'b0}));
        tick();
        check("wd_revoke", 32'({bus.grant, bus.err_timeout}), 32'({4'b0000, 1'b1}));
        tick();
        check("wd_pulse_end", 32'({bus.grant, bus.err_timeout}), 32'd0);
        tick();
        check("wd_next_grant", 32'(bus.grant), 32'b0010);

        // Release race: req drops in the same cycle as a strobe.
        bus.req = 4'b0010;
        tick();
        bus.req[1] = 1'b0;
        drive_px(1, 8'd77, 7'd77, 3'd5, 1'b0);
        tick();
        check("race_plot", 32'(bus.out_plot), 32'd0);
        check("race_grant", 32'(bus.grant), 32'd0);
        check("race_busy", 32'(bus.busy), 32'd1);
        bus.plot_in = '0;
        tick();
        check("race_idle", 32'(bus.busy), 32'd0);
        check("race_x", 32'(bus.out_x), 32'd9);
        tick();

        check("sb_empty", 32'(px_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
